// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with registered reads, write-first bypass and a clear sweep.
// Optional stored even parity with error flag when REGFILE_2R1W_PARITY_EN is defined.
module regfile_2r1w #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CS,
  input  logic             WE,
  input  logic [DEPTH-1:0] WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             RE0,
  input  logic             RE1,
  input  logic [DEPTH-1:0] RADDR0,
  input  logic [DEPTH-1:0] RADDR1,
  output logic [WIDTH-1:0] RDATA0,
  output logic [WIDTH-1:0] RDATA1,
  output logic             RVALID0,
  output logic             RVALID1,
  input  logic             CLR,
  output logic             BUSY
`ifdef REGFILE_2R1W_PARITY_EN
  ,
  input  logic             PINJ,
  output logic             PERR
`endif
);

  localparam int ENTRIES = 1 << DEPTH;
`ifdef REGFILE_2R1W_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [DEPTH-1:0] clr_cnt;
  logic [MW-1:0]    mem [ENTRIES];

  logic          idle;
  logic          wr_acc;
  logic          rd_acc0;
  logic          rd_acc1;
  logic [MW-1:0] wr_word;
  logic [MW-1:0] rd_word0;
  logic [MW-1:0] rd_word1;

  assign idle    = (state == IDLE);
  // A clear request in the same cycle wins over the write, which is dropped.
  assign wr_acc  = idle && !CS && WE && !CLR;
  assign rd_acc0 = idle && !CS && RE0;
  assign rd_acc1 = idle && !CS && RE1;

`ifdef REGFILE_2R1W_PARITY_EN
  assign wr_word = {(^WDATA) ^ PINJ, WDATA};
`else
  assign wr_word = WDATA;
`endif

  assign rd_word0 = (wr_acc && (WADDR == RADDR0)) ? wr_word : mem[RADDR0];
  assign rd_word1 = (wr_acc && (WADDR == RADDR1)) ? wr_word : mem[RADDR1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      clr_cnt <= '0;
      BUSY    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!CS && CLR) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            BUSY    <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + DEPTH'(1);
          if (&clr_cnt) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      mem[WADDR] <= wr_word;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RDATA0  <= '0;
      RDATA1  <= '0;
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
    end else begin
      RVALID0 <= rd_acc0;
      RVALID1 <= rd_acc1;
      if (rd_acc0) RDATA0 <= rd_word0[WIDTH-1:0];
      if (rd_acc1) RDATA1 <= rd_word1[WIDTH-1:0];
    end
  end

`ifdef REGFILE_2R1W_PARITY_EN
  // Sticky until reset so a single corrupted read is never lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PERR <= 1'b0;
    end else if ((rd_acc0 && (rd_word0[WIDTH] != ^rd_word0[WIDTH-1:0])) ||
                 (rd_acc1 && (rd_word1[WIDTH] != ^rd_word1[WIDTH-1:0]))) begin
      PERR <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: expected read data queued at issue, compared when RVALID arrives.
module tb_regfile_2r1w;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CS = 1'b1;
  logic       WE = 1'b0;
  logic       RE0 = 1'b0;
  logic       RE1 = 1'b0;
  logic       CLR = 1'b0;
  logic [4:0] WADDR = '0;
  logic [4:0] RADDR0 = '0;
  logic [4:0] RADDR1 = '0;
  logic [7:0] WDATA = '0;
  logic [7:0] RDATA0, RDATA1;
  logic       RVALID0, RVALID1, BUSY;
`ifdef REGFILE_2R1W_PARITY_EN
  logic       PINJ = 1'b0;
  logic       PERR;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] model[32];
  logic [7:0] exp0, exp1;

  always #5 CLK = ~CLK;

  regfile_2r1w #(.WIDTH(8), .DEPTH(5)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE0(RE0), .RE1(RE1), .RADDR0(RADDR0), .RADDR1(RADDR1),
    .RDATA0(RDATA0), .RDATA1(RDATA1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .CLR(CLR), .BUSY(BUSY)
`ifdef REGFILE_2R1W_PARITY_EN
    , .PINJ(PINJ), .PERR(PERR)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    CS = 1'b0; WE = 1'b0; RE0 = 1'b0; RE1 = 1'b0; CLR = 1'b0;
`ifdef REGFILE_2R1W_PARITY_EN
    PINJ = 1'b0;
`endif
  endtask

  task automatic write_all(input int seed);
    for (int i = 0; i < 32; i++) begin
      idle_in();
      WE = 1'b1; WADDR = 5'(i); WDATA = 8'(i * 7 + seed);
      model[i] = WDATA;
      tick();
    end
    idle_in();
  endtask

  task automatic test_reset();
    RST = 1'b1; CS = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({RDATA0, RDATA1} !== 16'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h/%h want 00/00", RDATA0, RDATA1);
    end
    n_cmp++;
    if ({RVALID0, RVALID1} !== 2'b00) begin
      n_err++; $display("FAIL reset_rvalid: got %b%b want 00", RVALID0, RVALID1);
    end
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b want 0", BUSY);
    end
    RST = 1'b0;
    idle_in();
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      RE0 = 1'b1; RADDR0 = (k == 0) ? 5'd0 : 5'd31;
      RE1 = 1'b1; RADDR1 = (k == 0) ? 5'd31 : 5'd0;
      q0.push_back(model[RADDR0]); q1.push_back(model[RADDR1]);
      tick();
      idle_in();
      exp0 = q0.pop_front(); exp1 = q1.pop_front();
      n_cmp++;
      if (RVALID0 !== 1'b1 || RDATA0 !== exp0) begin
        n_err++; $display("FAIL reset_read0: got v=%b d=%h want v=1 d=%h", RVALID0, RDATA0, exp0);
      end
      n_cmp++;
      if (RVALID1 !== 1'b1 || RDATA1 !== exp1) begin
        n_err++; $display("FAIL reset_read1: got v=%b d=%h want v=1 d=%h", RVALID1, RDATA1, exp1);
      end
    end
  endtask

  task automatic test_write_read();
    WE = 1'b1; WADDR = 5'd3; WDATA = 8'hA5; model[3] = 8'hA5;
    tick();
    idle_in();
    RE0 = 1'b1; RADDR0 = 5'd3; q0.push_back(model[3]);
    tick();
    idle_in();
    exp0 = q0.pop_front();
    n_cmp++;
    if (RVALID0 !== 1'b1 || RDATA0 !== exp0) begin
      n_err++; $display("FAIL wr_rd: got v=%b d=%h want v=1 d=%h", RVALID0, RDATA0, exp0);
    end
    tick();
    n_cmp++;
    if (RVALID0 !== 1'b0 || RDATA0 !== 8'hA5) begin
      n_err++; $display("FAIL rd_hold: got v=%b d=%h want v=0 d=a5", RVALID0, RDATA0);
    end
    CS = 1'b1; WE = 1'b1; WADDR = 5'd3; WDATA = 8'h5A; RE0 = 1'b1; RADDR0 = 5'd3;
    tick();
    idle_in();
    n_cmp++;
    if (RVALID0 !== 1'b0 || RDATA0 !== 8'hA5) begin
      n_err++; $display("FAIL cs_block_rd: got v=%b d=%h want v=0 d=a5", RVALID0, RDATA0);
    end
    RE0 = 1'b1; RADDR0 = 5'd3; q0.push_back(model[3]);
    tick();
    idle_in();
    exp0 = q0.pop_front();
    n_cmp++;
    if (RVALID0 !== 1'b1 || RDATA0 !== exp0) begin
      n_err++; $display("FAIL cs_block_wr: got v=%b d=%h want v=1 d=%h", RVALID0, RDATA0, exp0);
    end
  endtask

  task automatic test_bypass();
    for (int k = 0; k < 2; k++) begin
      WE = 1'b1; RE0 = 1'b1; RE1 = 1'b1;
      WADDR = (k == 0) ? 5'd7 : 5'd9;
      WDATA = (k == 0) ? 8'h3C : 8'h11;
      RADDR0 = (k == 0) ? 5'd7 : 5'd3;
      RADDR1 = (k == 0) ? 5'd7 : 5'd9;
      model[WADDR] = WDATA;
      q0.push_back(model[RADDR0]); q1.push_back(model[RADDR1]);
      tick();
      idle_in();
      exp0 = q0.pop_front(); exp1 = q1.pop_front();
      n_cmp++;
      if (RVALID0 !== 1'b1 || RDATA0 !== exp0) begin
        n_err++; $display("FAIL bypass0 k%0d: got v=%b d=%h want v=1 d=%h", k, RVALID0, RDATA0, exp0);
      end
      n_cmp++;
      if (RVALID1 !== 1'b1 || RDATA1 !== exp1) begin
        n_err++; $display("FAIL bypass1 k%0d: got v=%b d=%h want v=1 d=%h", k, RVALID1, RDATA1, exp1);
      end
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    write_all(1);
    CLR = 1'b1; WE = 1'b1; WADDR = 5'd5; WDATA = 8'hFF;
    RE0 = 1'b1; RADDR0 = 5'd5; RE1 = 1'b1; RADDR1 = 5'd6;
    q0.push_back(model[5]);
    tick();
    exp0 = q0.pop_front();
    n_cmp++;
    if (RVALID0 !== 1'b1 || RDATA0 !== exp0) begin
      n_err++; $display("FAIL clr_same_cycle_rd: got v=%b d=%h want v=1 d=%h", RVALID0, RDATA0, exp0);
    end
    busy_cnt = (BUSY === 1'b1) ? 1 : 0;
    for (int c = 0; c < 64 && BUSY === 1'b1; c++) begin
      CS = (c >= 10 && c < 15);
      tick();
      n_cmp++;
      if ({RVALID0, RVALID1} !== 2'b00) begin
        n_err++; $display("FAIL busy_rvalid c%0d: got %b%b want 00", c, RVALID0, RVALID1);
      end
      if (BUSY === 1'b1) busy_cnt++;
    end
    idle_in();
    n_cmp++;
    if (busy_cnt !== 32) begin
      n_err++; $display("FAIL busy_len: got %0d want 32", busy_cnt);
    end
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    for (int i = 0; i < 32; i++) begin
      RE0 = 1'b1; RADDR0 = 5'(i); RE1 = 1'b1; RADDR1 = 5'(31 - i);
      q0.push_back(model[RADDR0]); q1.push_back(model[RADDR1]);
      tick();
      idle_in();
      exp0 = q0.pop_front(); exp1 = q1.pop_front();
      n_cmp++;
      if (RVALID0 !== 1'b1 || RDATA0 !== exp0 || RVALID1 !== 1'b1 || RDATA1 !== exp1) begin
        n_err++;
        $display("FAIL cleared_read a%0d: got %b/%h %b/%h want 1/%h 1/%h",
                 i, RVALID0, RDATA0, RVALID1, RDATA1, exp0, exp1);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    write_all(2);
    CLR = 1'b1;
    tick();
    idle_in();
    repeat (10) tick();
    n_cmp++;
    if (BUSY !== 1'b1) begin
      n_err++; $display("FAIL sweep_running: got %b want 1", BUSY);
    end
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if (BUSY !== 1'b0 || RVALID0 !== 1'b0 || RDATA0 !== 8'h00) begin
      n_err++; $display("FAIL async_rst: got busy=%b v=%b d=%h want 0 0 00", BUSY, RVALID0, RDATA0);
    end
    tick();
    RST = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    WE = 1'b1; WADDR = 5'd10; WDATA = 8'h77; model[10] = 8'h77;
    tick();
    idle_in();
    for (int i = 0; i < 32; i++) begin
      RE0 = 1'b1; RADDR0 = 5'(i); RE1 = 1'b1; RADDR1 = 5'(i ^ 5);
      q0.push_back(model[RADDR0]); q1.push_back(model[RADDR1]);
      tick();
      idle_in();
      exp0 = q0.pop_front(); exp1 = q1.pop_front();
      n_cmp++;
      if (RVALID0 !== 1'b1 || RDATA0 !== exp0 || RVALID1 !== 1'b1 || RDATA1 !== exp1) begin
        n_err++;
        $display("FAIL post_rst_read a%0d: got %b/%h %b/%h want 1/%h 1/%h",
                 i, RVALID0, RDATA0, RVALID1, RDATA1, exp0, exp1);
      end
    end
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL post_rst_busy: got %b want 0", BUSY);
    end
  endtask

`ifdef REGFILE_2R1W_PARITY_EN
  task automatic test_parity();
    n_cmp++;
    if (PERR !== 1'b0) begin
      n_err++; $display("FAIL perr_init: got %b want 0", PERR);
    end
    WE = 1'b1; WADDR = 5'd2; WDATA = 8'h01; PINJ = 1'b1;
    tick();
    idle_in();
    n_cmp++;
    if (PERR !== 1'b0) begin
      n_err++; $display("FAIL perr_on_write: got %b want 0", PERR);
    end
    RE0 = 1'b1; RADDR0 = 5'd2; q0.push_back(8'h01);
    tick();
    idle_in();
    exp0 = q0.pop_front();
    n_cmp++;
    if (PERR !== 1'b1 || RDATA0 !== exp0) begin
      n_err++; $display("FAIL perr_set: got perr=%b d=%h want 1 %h", PERR, RDATA0, exp0);
    end
    repeat (5) tick();
    n_cmp++;
    if (PERR !== 1'b1) begin
      n_err++; $display("FAIL perr_sticky: got %b want 1", PERR);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    WE = 1'b1; WADDR = 5'd4; WDATA = 8'h03;
    tick();
    idle_in();
    RE0 = 1'b1; RADDR0 = 5'd4;
    tick();
    idle_in();
    n_cmp++;
    if (PERR !== 1'b0 || RDATA0 !== 8'h03) begin
      n_err++; $display("FAIL perr_clean: got perr=%b d=%h want 0 03", PERR, RDATA0);
    end
    WE = 1'b1; WADDR = 5'd6; WDATA = 8'h07; PINJ = 1'b1; RE1 = 1'b1; RADDR1 = 5'd6;
    tick();
    idle_in();
    n_cmp++;
    if (PERR !== 1'b1 || RDATA1 !== 8'h07) begin
      n_err++; $display("FAIL perr_bypass: got perr=%b d=%h want 1 07", PERR, RDATA1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_reset_mid_sweep();
`ifdef REGFILE_2R1W_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule
